// File: rtl/uart_receive.sv
// -----------------------------------------------------------------------------
// uart_receive
// Receive half of the team UART. Deserialises 8N1 frames arriving on rxd
// (start bit 0, eight data bits LSB first, stop bit 1, idle high) using an
// oversampled baud tick. The received byte and its status are read at bus
// address 0.
//
// Optional feature (macro UART_RX_MAJORITY_EN):
//   defined     - data and stop bits are the 2-of-3 majority of rxd_s taken on
//                 the last three ticks of each bit period
//   not defined - single sample on the last tick of each bit period
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   brg_sample  one-clock pulse at OVERSAMPLE x baud rate
//   rxd         serial input, asynchronous to clk
//   iocs        chip select
//   iorw        1 = read, 0 = write
//   ioaddr      register address, 0 = data
//   rx_data     last received byte
//   rda         receive data available
//   frm_err     sticky framing error (stop bit sampled 0)
//   ovr_err     sticky overrun (byte completed while rda already set)
// -----------------------------------------------------------------------------
module uart_receive #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       brg_sample,
    input  logic       rxd,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    output logic [7:0] rx_data,
    output logic       rda,
    output logic       frm_err,
    output logic       ovr_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_r,    state_nxt_s;
    logic [TW-1:0]   tick_cnt_r, tick_cnt_nxt_s;
    logic [3:0]      bit_cnt_r,  bit_cnt_nxt_s;
    logic [7:0]      shift_r,    shift_nxt_s;
    logic [7:0]      rx_data_r,  rx_data_nxt_s;
    logic            rda_r,      rda_nxt_s;
    logic            frm_err_r,  frm_err_nxt_s;
    logic            ovr_err_r,  ovr_err_nxt_s;
    logic            rxd_meta_r;
    logic            rxd_s;
    logic            bit_val_s;
    logic            read_s;
    logic            done_s;

    assign read_s = iocs & iorw & (ioaddr == 2'd0);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [TW-1:0] TICK_VOTE0 = TW'(OVERSAMPLE - 3);
    localparam logic [TW-1:0] TICK_VOTE1 = TW'(OVERSAMPLE - 2);

    // vote_r[1] holds the sample from OVERSAMPLE-3, vote_r[0] from OVERSAMPLE-2
    logic [1:0] vote_r;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Capture the two early votes of each data/stop bit period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_r <= 2'b00;
        end else if (brg_sample && ((state_r == DATA) || (state_r == STOP))) begin
            if (tick_cnt_r == TICK_VOTE0) begin
                vote_r[1] <= rxd_s;
            end else if (tick_cnt_r == TICK_VOTE1) begin
                vote_r[0] <= rxd_s;
            end else begin
                vote_r <= vote_r;
            end
        end else begin
            vote_r <= vote_r;
        end
    end

    // The decision still lands on the last tick, so bit timing is unchanged
    assign bit_val_s = maj3(vote_r[1], vote_r[0], rxd_s);
`else
    assign bit_val_s = rxd_s;
`endif

    // Two-flop synchroniser plus all FSM, datapath and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta_r <= 1'b1;
            rxd_s      <= 1'b1;
            state_r    <= IDLE;
            tick_cnt_r <= '0;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'h00;
            rx_data_r  <= 8'h00;
            rda_r      <= 1'b0;
            frm_err_r  <= 1'b0;
            ovr_err_r  <= 1'b0;
        end else begin
            rxd_meta_r <= rxd;
            rxd_s      <= rxd_meta_r;
            state_r    <= state_nxt_s;
            tick_cnt_r <= tick_cnt_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            rx_data_r  <= rx_data_nxt_s;
            rda_r      <= rda_nxt_s;
            frm_err_r  <= frm_err_nxt_s;
            ovr_err_r  <= ovr_err_nxt_s;
        end
    end

    // Next-state, datapath and status logic; everything holds between ticks
    always_comb begin
        state_nxt_s    = state_r;
        tick_cnt_nxt_s = tick_cnt_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        shift_nxt_s    = shift_r;
        done_s         = 1'b0;
        rx_data_nxt_s  = rx_data_r;
        rda_nxt_s      = rda_r;
        frm_err_nxt_s  = frm_err_r;
        ovr_err_nxt_s  = ovr_err_r;

        if (brg_sample) begin
            case (state_r)
                IDLE: begin
                    if (!rxd_s) begin
                        state_nxt_s    = START;
                        tick_cnt_nxt_s = '0;
                    end else begin
                        state_nxt_s    = IDLE;
                    end
                end
                START: begin
                    if (tick_cnt_r == TICK_MID) begin
                        tick_cnt_nxt_s = '0;
                        if (!rxd_s) begin
                            state_nxt_s   = DATA;
                            bit_cnt_nxt_s = 4'd0;
                        end else begin
                            // line went back high before mid start: noise
                            state_nxt_s   = IDLE;
                        end
                    end else begin
                        tick_cnt_nxt_s = tick_cnt_r + TICK_ONE;
                    end
                end
                DATA: begin
                    if (tick_cnt_r == TICK_LAST) begin
                        // LSB arrives first, so shift in at the top
                        shift_nxt_s    = {bit_val_s, shift_r[7:1]};
                        tick_cnt_nxt_s = '0;
                        bit_cnt_nxt_s  = bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd7) begin
                            state_nxt_s = STOP;
                        end else begin
                            state_nxt_s = DATA;
                        end
                    end else begin
                        tick_cnt_nxt_s = tick_cnt_r + TICK_ONE;
                    end
                end
                STOP: begin
                    if (tick_cnt_r == TICK_LAST) begin
                        done_s         = 1'b1;
                        tick_cnt_nxt_s = '0;
                        state_nxt_s    = IDLE;
                    end else begin
                        tick_cnt_nxt_s = tick_cnt_r + TICK_ONE;
                    end
                end
                default: begin
                    state_nxt_s    = IDLE;
                    tick_cnt_nxt_s = '0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end

        // A completing frame beats a coincident read: the new byte stays
        // available and its flags describe only that frame.
        if (done_s) begin
            rx_data_nxt_s = shift_r;
            rda_nxt_s     = 1'b1;
            if (read_s) begin
                frm_err_nxt_s = ~bit_val_s;
                ovr_err_nxt_s = 1'b0;
            end else begin
                frm_err_nxt_s = frm_err_r | ~bit_val_s;
                ovr_err_nxt_s = ovr_err_r | rda_r;
            end
        end else if (read_s) begin
            rda_nxt_s     = 1'b0;
            frm_err_nxt_s = 1'b0;
            ovr_err_nxt_s = 1'b0;
        end else begin
            rda_nxt_s     = rda_r;
        end
    end

    assign rx_data = rx_data_r;
    assign rda     = rda_r;
    assign frm_err = frm_err_r;
    assign ovr_err = ovr_err_r;

endmodule

// File: tb/tb_uart_receive.sv
// -----------------------------------------------------------------------------
// tb_uart_receive
// Directed bench for uart_receive. A frame-level reference model (offset of
// each tick from the detected start edge, sample points at fixed offsets)
// predicts rx_data/rda/frm_err/ovr_err; one compare process checks the DUT
// against it every falling edge, and literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_uart_receive;

    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
    localparam int STOP_OFF = OS / 2 + 9 * OS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       brg_sample = 1'b0;
    logic       rxd = 1'b1;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'd0;
    logic [7:0] rx_data;
    logic       rda;
    logic       frm_err;
    logic       ovr_err;

    int tests = 0;
    int fails = 0;

    uart_receive #(.OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .rst       (rst),
        .brg_sample(brg_sample),
        .rxd       (rxd),
        .iocs      (iocs),
        .iorw      (iorw),
        .ioaddr    (ioaddr),
        .rx_data   (rx_data),
        .rda       (rda),
        .frm_err   (frm_err),
        .ovr_err   (ovr_err)
    );

    always #5 clk = ~clk;

    // baud tick: one clock in every TICK_DIV
    initial begin
        int tcnt;
        tcnt = 0;
        forever begin
            @(negedge clk);
            tcnt = (tcnt + 1) % TICK_DIV;
            brg_sample = (tcnt == 0);
        end
    end

    // ---------------- reference model ----------------
    logic       h1, h2;          // rxd as seen after the 2-clock input latency
    logic [1:0] th;              // rxd (delayed) on the previous two ticks
    logic       m_busy;
    int         m_off;
    logic [7:0] m_byte;
    logic [7:0] exp_data;
    logic       exp_rda, exp_frm, exp_ovr;
    logic       m_bit, m_rd, m_done;

`ifdef UART_RX_MAJORITY_EN
    assign m_bit = (th[0] & th[1]) | (th[0] & h2) | (th[1] & h2);
`else
    assign m_bit = h2;
`endif
    assign m_rd   = iocs && iorw && (ioaddr == 2'd0);
    assign m_done = brg_sample && m_busy && (m_off + 1 == STOP_OFF);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h1 <= 1'b1; h2 <= 1'b1; th <= 2'b11;
            m_busy <= 1'b0; m_off <= 0; m_byte <= 8'h00;
            exp_data <= 8'h00; exp_rda <= 1'b0; exp_frm <= 1'b0; exp_ovr <= 1'b0;
        end else begin
            h1 <= rxd;
            h2 <= h1;
            if (brg_sample) begin
                th <= {th[0], h2};
                if (!m_busy) begin
                    if (!h2) begin
                        m_busy <= 1'b1;
                        m_off  <= 0;
                    end
                end else begin
                    m_off <= m_off + 1;
                    if ((m_off + 1 == OS / 2) && h2) m_busy <= 1'b0;
                    for (int k = 0; k < 8; k++)
                        if (m_off + 1 == OS / 2 + OS * (k + 1)) m_byte[k] <= m_bit;
                    if (m_off + 1 == STOP_OFF) m_busy <= 1'b0;
                end
            end
            if (m_done) begin
                exp_data <= m_byte;
                exp_rda  <= 1'b1;
                exp_frm  <= m_rd ? ~m_bit : (exp_frm | ~m_bit);
                exp_ovr  <= m_rd ? 1'b0 : (exp_ovr | exp_rda);
            end else if (m_rd) begin
                exp_rda <= 1'b0;
                exp_frm <= 1'b0;
                exp_ovr <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // continuous comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("model rx_data", rx_data, exp_data);
                check("model rda", {7'd0, rda}, {7'd0, exp_rda});
                check("model frm_err", {7'd0, frm_err}, {7'd0, exp_frm});
                check("model ovr_err", {7'd0, ovr_err}, {7'd0, exp_ovr});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (brg_sample !== 1'b1);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rxd = 1'b1;
        wait_ticks(n);
    endtask

    // Caller must be just past a tick edge. Leaves rxd at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int glitch_bit, input bit rd_at_end);
        @(negedge clk);
        rxd = 1'b0;
        wait_ticks(OS);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rxd = b[k];
            if (k == glitch_bit) begin
                wait_ticks(OS / 2);
                @(negedge clk);
                rxd = 1'b0;
                wait_ticks(1);
                @(negedge clk);
                rxd = b[k];
                wait_ticks(OS / 2 - 1);
            end else begin
                wait_ticks(OS);
            end
        end
        @(negedge clk);
        rxd = stop_bit;
        if (rd_at_end) begin
            // put the read on exactly the clock whose edge completes the frame
            wait_ticks(OS / 2);
            @(negedge clk);
            repeat (TICK_DIV - 1) @(negedge clk);
            iocs = 1'b1; iorw = 1'b1; ioaddr = 2'd0;
            @(negedge clk);
            iocs = 1'b0; iorw = 1'b0;
            wait_ticks(OS / 2 - 1);
        end else begin
            wait_ticks(OS);
        end
    endtask

    task automatic bus(input logic rw, input logic [1:0] a);
        @(negedge clk);
        iocs = 1'b1; iorw = rw; ioaddr = a;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b0; ioaddr = 2'd0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset rx_data", rx_data, 8'h00);
        check("reset rda", {7'd0, rda}, 8'h00);
        check("reset frm_err", {7'd0, frm_err}, 8'h00);
        check("reset ovr_err", {7'd0, ovr_err}, 8'h00);

        // basic frame, ignored accesses, then a real read
        idle(4);
        send_frame(8'hA5, 1'b1, -1, 1'b0);
        @(negedge clk);
        check("a5 rx_data", rx_data, 8'hA5);
        check("a5 rda", {7'd0, rda}, 8'h01);
        check("a5 frm_err", {7'd0, frm_err}, 8'h00);
        bus(1'b0, 2'd0);
        check("write no effect rda", {7'd0, rda}, 8'h01);
        bus(1'b1, 2'd1);
        check("addr1 no effect rda", {7'd0, rda}, 8'h01);
        bus(1'b1, 2'd0);
        check("read clears rda", {7'd0, rda}, 8'h00);
        check("read keeps rx_data", rx_data, 8'hA5);

        // short low glitch is a false start
        idle(2);
        @(negedge clk);
        rxd = 1'b0;
        wait_ticks(4);
        idle(24);
        @(negedge clk);
        check("glitch rda", {7'd0, rda}, 8'h00);
        idle(2);
        send_frame(8'h3C, 1'b1, -1, 1'b0);
        @(negedge clk);
        check("3c rx_data", rx_data, 8'h3C);
        bus(1'b1, 2'd0);

        // framing error
        idle(2);
        send_frame(8'h81, 1'b0, -1, 1'b0);
        idle(20);
        @(negedge clk);
        check("81 rx_data", rx_data, 8'h81);
        check("81 rda", {7'd0, rda}, 8'h01);
        check("81 frm_err", {7'd0, frm_err}, 8'h01);
        bus(1'b1, 2'd0);
        check("read clears frm_err", {7'd0, frm_err}, 8'h00);

        // overrun with back-to-back frames
        idle(2);
        send_frame(8'h11, 1'b1, -1, 1'b0);
        send_frame(8'h22, 1'b1, -1, 1'b0);
        @(negedge clk);
        check("ovr rx_data", rx_data, 8'h22);
        check("ovr ovr_err", {7'd0, ovr_err}, 8'h01);
        bus(1'b1, 2'd0);
        check("read clears ovr_err", {7'd0, ovr_err}, 8'h00);

        // read on the completion cycle: completion wins, no overrun
        idle(2);
        send_frame(8'h11, 1'b1, -1, 1'b0);
        send_frame(8'h22, 1'b1, -1, 1'b1);
        @(negedge clk);
        check("race rda", {7'd0, rda}, 8'h01);
        check("race ovr_err", {7'd0, ovr_err}, 8'h00);
        check("race rx_data", rx_data, 8'h22);
        bus(1'b1, 2'd0);

        // one-tick low glitch on the last sample tick of data bit 1
        idle(2);
        send_frame(8'hFF, 1'b1, 1, 1'b0);
        @(negedge clk);
`ifdef UART_RX_MAJORITY_EN
        check("vote rx_data", rx_data, 8'hFF);
`else
        check("single rx_data", rx_data, 8'hFD);
`endif
        bus(1'b1, 2'd0);

        // reset during bit 4 of 0xFF aborts the frame
        idle(2);
        @(negedge clk);
        rxd = 1'b0;
        wait_ticks(OS);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rxd = 1'b1;
            wait_ticks(OS);
        end
        @(negedge clk);
        rxd = 1'b1;
        wait_ticks(OS / 2);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort rx_data", rx_data, 8'h00);
        check("abort rda", {7'd0, rda}, 8'h00);
        idle(40);
        send_frame(8'h5A, 1'b1, -1, 1'b0);
        @(negedge clk);
        check("5a rx_data", rx_data, 8'h5A);
        check("5a rda", {7'd0, rda}, 8'h01);
        check("5a frm_err", {7'd0, frm_err}, 8'h00);
        check("5a ovr_err", {7'd0, ovr_err}, 8'h00);

        idle(4);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
